rom_burst_reader: RTL and testbench

Parametrised read-only memory with a valid/ready request port and a streaming output port. One request (start address, length) produces a burst of consecutive words, with address wrap-around, full throughput and lossless backpressure. It is the next-generation ROM for the challenge blocks, replacing the fixed 8-bit/16-entry single-address ROM wherever a consumer streams tables or needs flow control.

---
 rtl/rom_burst_reader.sv | 151 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Read-only table memory that streams a burst of consecutive words per request,
// with address wrap-around, one word per cycle and lossless output backpressure.
module rom_burst_reader #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    PATTERN_WORDS = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = '1,
  parameter                        INIT_FILE     = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] rom_mem [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [3:0] NIB = 4'(i);
      assign rom_mem[i] = (i < PATTERN_WORDS) ? {(DATA_WIDTH/4){NIB}} : FILL_VALUE;
    end
  endgenerate

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;

  logic                  infl_q, infl_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_last_q, rd_last_d;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [1:0]            cnt_w;

  logic accept;
  logic pop;
  logic room;
  logic issue;

  assign dout_valid = (buf_cnt_q != 2'd0);
  assign dout_data  = buf_data_q[0];
  assign dout_last  = dout_valid & buf_last_q[0];
  assign pop        = dout_valid & dout_ready;

  assign req_ready  = (state_q == S_IDLE) & ~rst;
  assign busy       = (state_q == S_BURST);
  assign accept     = req_valid & req_ready;

  // Occupancy after this edge must stay within the 2-entry buffer.
  assign room  = ({1'b0, buf_cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign issue = (state_q == S_BURST) && (remain_q != '0) && room;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          remain_d = req_len;
          if (req_len != '0) begin
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - (ADDR_WIDTH+1)'(1);
        end
        if (pop && dout_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    infl_d    = issue;
    rd_data_d = rd_data_q;
    rd_last_d = rd_last_q;
    if (issue) begin
      rd_data_d = rom_mem[addr_q];
      rd_last_d = (remain_q == (ADDR_WIDTH+1)'(1));
    end
  end

  // Head is always entry 0: a pop shifts, then an arriving word lands behind it.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    cnt_w      = buf_cnt_q;
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      cnt_w         = cnt_w - 2'd1;
    end
    if (infl_q) begin
      buf_data_d[cnt_w[0]] = rd_data_q;
      buf_last_d[cnt_w[0]] = rd_last_q;
      cnt_w                = cnt_w + 2'd1;
    end
    buf_cnt_d = cnt_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      infl_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      buf_data_q <= '{default: '0};
      buf_last_q <= '{default: 1'b0};
      buf_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      infl_q     <= infl_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: a queue-based reference of the expected word stream
// checked every cycle, plus directed bursts with hand-computed values and timing.
module tb_rom_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW:0]   req_len;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic          dout_last;
  logic          busy;

  rom_burst_reader dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference contents: low 8 entries repeat their index in both nibbles, rest all ones.
  function automatic logic [DW-1:0] rom_ref(input int a);
    return (a < 8) ? DW'(a * 17) : 8'hFF;
  endfunction

  logic [DW:0]   exp_q [$];
  logic          busy_m = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      exp_q.delete();
      busy_m     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, busy_m);
      check("req_ready", req_ready, !busy_m);
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1);
        check("stall_data", dout_data, prev_data);
        check("stall_last", dout_last, prev_last);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", dout_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", dout_data, e[DW-1:0]);
          check("stream_last", dout_last, e[DW]);
          if (e[DW]) busy_m = 1'b0;
        end
      end
      if (req_valid && req_ready) begin
        for (int k = 0; k < int'(req_len); k++)
          exp_q.push_back({(k == int'(req_len) - 1), rom_ref((int'(req_addr) + k) % DEPTH)});
        if (req_len != 0) busy_m = 1'b1;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_last  = dout_last;
    end
  end

  // Returns one cycle after the accepting edge (E0 + 1).
  task automatic request(input int a, input int l);
    int cnt;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_len   = (AW+1)'(l);
    cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("req_accept_timeout", cnt < 50, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int mode);
    int cyc;
    cyc = 0;
    while ((busy || dout_valid) && cyc < 300) begin
      case (mode)
        1:       dout_ready = (cyc % 2 == 0);
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    dout_ready = 1'b1;
    check("drain_timeout", cyc < 300, 1);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic lit_burst(input string tag, input int a, input int l, input logic [7:0] exp [4]);
    dout_ready = 1'b1;
    request(a, l);
    check({tag, "_busy_e0"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_lat"}, dout_valid, 0);
    for (int k = 0; k < l; k++) begin
      @(posedge clk); #1;
      check({tag, "_valid"}, dout_valid, 1);
      check({tag, "_data"}, dout_data, exp[k]);
      check({tag, "_last"}, dout_last, (k == l - 1));
    end
    @(posedge clk); #1;
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ready_end"}, req_ready, 1);
    check({tag, "_valid_end"}, dout_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    dout_ready = 1'b1;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_req_ready", req_ready, 1);

    lit_burst("single", 3, 1, '{8'h33, 8'h00, 8'h00, 8'h00});
    lit_burst("bound", 6, 4, '{8'h66, 8'h77, 8'hFF, 8'hFF});
    lit_burst("wrap", 14, 4, '{8'hFF, 8'hFF, 8'h00, 8'h11});

    // Full throughput: busy spans exactly len + 2 cycles after accept.
    dout_ready = 1'b1;
    request(0, 20);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("len20_cycles", cyc, 22);
    check("len20_drained", exp_q.size(), 0);

    request(0, 8);
    drain(1);
    request(0, 8);
    drain(2);
    request(5, 13);
    drain(2);
    request(12, 31);
    drain(2);

    request(9, 0);
    for (int k = 0; k < 4; k++) begin
      check("len0_valid", dout_valid, 0);
      check("len0_ready", req_ready, 1);
      check("len0_busy", busy, 0);
      @(posedge clk); #1;
    end

    // Reset while the third word of a len-8 burst is on the output.
    dout_ready = 1'b1;
    request(0, 8);
    repeat (4) @(posedge clk);
    #1;
    check("mid_word3", dout_data, 8'h22);
    check("mid_valid", dout_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_data", dout_data, 0);
    check("mid_rst_last", dout_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rel_ready", req_ready, 1);

    lit_burst("after_rst", 2, 2, '{8'h22, 8'h33, 8'h00, 8'h00});

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
